bp_nonsynth_if_monitor: RTL and testbench

- Non-synthesizable, runtime, cycle-accurate protocol monitor for BlackParrot valid/ready and valid/yumi interfaces.
- Generalises the static interface width and parameter checks into per-channel dynamic checking across num_channels_p independent channels.
- Instantiated alongside the core or tile in the testbench; observes handshakes passively and reports sticky per-channel violations, transaction counts and worst-case stall length.

---
 rtl/bp_common_pkg.sv | 27 ++
 rtl/bp_nonsynth_if_monitor_channel.sv | 144 ++++++++++++++
 rtl/bp_nonsynth_if_monitor.sv | 81 ++++++++
 tb/tb_bp_nonsynth_if_monitor.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/bp_common_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bp_common_pkg
// Description : Shared types for the BlackParrot interface monitor:
//               error codes and per-channel monitor FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package bp_common_pkg;

    // Sticky error codes reported per channel (lower value wins on a tie)
    typedef enum logic [2:0] {
        e_mon_none     = 3'd0,
        e_mon_drop     = 3'd1,
        e_mon_unstable = 3'd2,
        e_mon_timeout  = 3'd3,
        e_mon_yumi_nov = 3'd4
    } bp_if_mon_err_e;

    // Per-channel handshake tracking state
    typedef enum logic [1:0] {
        e_idle  = 2'd0,
        e_stall = 2'd1,
        e_error = 2'd2
    } bp_if_mon_state_e;

endpackage : bp_common_pkg
`default_nettype wire

// File: rtl/bp_nonsynth_if_monitor_channel.sv
`default_nettype none
// ============================================================================
// Module      : bp_nonsynth_if_monitor_channel
// Description : Single-channel valid/ready (or valid/yumi) protocol checker.
//               Tracks stalls, captures the stalled payload, counts accepted
//               handshakes and latches the first protocol error.
//               Optional macro BP_NONSYNTH_IF_MONITOR_HALT_EN: report the
//               first error with $error and end simulation one cycle later.
// Revision    : 1.0 - initial release
// ============================================================================
module bp_nonsynth_if_monitor_channel
    import bp_common_pkg::*;
#(
    parameter int data_width_p  = 64,
    parameter int timeout_p     = 1024,
    parameter int yumi_mode_p   = 0,
    parameter int count_width_p = 32
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_clear,
    input  logic                     i_v,
    input  logic                     i_ready_yumi,
    input  logic [data_width_p-1:0]  i_data,
    output logic                     o_err,
    output logic [2:0]               o_err_code,
    output logic [count_width_p-1:0] o_txn_count,
    output logic [count_width_p-1:0] o_stall_cnt
);

    localparam logic [count_width_p-1:0] c_timeout = count_width_p'(timeout_p);

    bp_if_mon_state_e         r_state;
    bp_if_mon_err_e           r_err_code;
    logic                     r_err;
    logic [data_width_p-1:0]  r_cap;
    logic [count_width_p-1:0] r_stall_cnt;
    logic [count_width_p-1:0] r_count;

    logic                     w_hs;
    logic                     w_drop;
    logic                     w_unstable;
    logic                     w_timeout;
    logic                     w_yumi_nov;
    logic                     w_err_new;
    bp_if_mon_err_e           w_code;

    assign w_hs       = i_v & i_ready_yumi;
    assign w_drop     = (r_state == e_stall) & ~i_v;
    assign w_unstable = (r_state == e_stall) & i_v & (i_data != r_cap);
    assign w_timeout  = (timeout_p != 0) && (r_state == e_stall) && (r_stall_cnt == c_timeout);
    assign w_yumi_nov = (yumi_mode_p != 0) && i_ready_yumi && !i_v;

    // Pick the lowest-numbered error detected this cycle
    always_comb begin
        w_code = e_mon_none;
        if (w_drop)          w_code = e_mon_drop;
        else if (w_unstable) w_code = e_mon_unstable;
        else if (w_timeout)  w_code = e_mon_timeout;
        else if (w_yumi_nov) w_code = e_mon_yumi_nov;
    end

    // Only the first error is recorded; e_error absorbs until clear/reset
    assign w_err_new = (w_code != e_mon_none) && (r_state != e_error);

    // Channel FSM, capture register, stall and transaction counters
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= e_idle;
            r_err       <= 1'b0;
            r_err_code  <= e_mon_none;
            r_cap       <= '0;
            r_stall_cnt <= '0;
            r_count     <= '0;
        end else if (i_clear) begin
            r_state     <= e_idle;
            r_err       <= 1'b0;
            r_err_code  <= e_mon_none;
            r_stall_cnt <= '0;
            r_count     <= '0;
        end else begin
            // Accepted handshakes are counted in every state, saturating
            if (w_hs && (r_count != '1)) begin
                r_count <= r_count + 1'b1;
            end
            if (w_err_new) begin
                r_state    <= e_error;
                r_err      <= 1'b1;
                r_err_code <= w_code;
            end else begin
                case (r_state)
                    e_idle: begin
                        if (i_v && !i_ready_yumi) begin
                            r_cap       <= i_data;
                            r_stall_cnt <= {{(count_width_p-1){1'b0}}, 1'b1};
                            r_state     <= e_stall;
                        end
                    end
                    e_stall: begin
                        if (w_hs) begin
                            r_stall_cnt <= '0;
                            r_state     <= e_idle;
                        end else if (r_stall_cnt != '1) begin
                            r_stall_cnt <= r_stall_cnt + 1'b1;
                        end
                    end
                    default: begin
                        r_state <= e_error;
                    end
                endcase
            end
        end
    end

`ifdef BP_NONSYNTH_IF_MONITOR_HALT_EN
    logic [63:0] r_cycle;
    logic        r_halt;

    // Report the first latched error, then end the simulation one cycle later
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cycle <= '0;
            r_halt  <= 1'b0;
        end else begin
            r_cycle <= r_cycle + 1'b1;
            if (w_err_new && !i_clear) begin
                $error("%m: protocol error code %0d at cycle %0d, captured %h current %h",
                       w_code, r_cycle, r_cap, i_data);
                r_halt <= 1'b1;
            end
            if (r_halt) begin
                $finish;
            end
        end
    end
`endif

    assign o_err       = r_err;
    assign o_err_code  = r_err_code;
    assign o_txn_count = r_count;
    assign o_stall_cnt = r_stall_cnt;

endmodule : bp_nonsynth_if_monitor_channel
`default_nettype wire

// File: rtl/bp_nonsynth_if_monitor.sv
`default_nettype none
// ============================================================================
// Module      : bp_nonsynth_if_monitor
// Description : Passive multi-channel protocol monitor for BlackParrot
//               valid/ready and valid/yumi interfaces. One checker per
//               channel, plus a running worst-case stall and an error OR.
//               Optional macro BP_NONSYNTH_IF_MONITOR_HALT_EN (see channel).
// Revision    : 1.0 - initial release
// ============================================================================
module bp_nonsynth_if_monitor
    import bp_common_pkg::*;
#(
    parameter int num_channels_p = 4,
    parameter int data_width_p   = 64,
    parameter int timeout_p      = 1024,
    parameter int yumi_mode_p    = 0,
    parameter int count_width_p  = 32
) (
    input  logic                                    clk_i,
    input  logic                                    reset_i,
    input  logic                                    clear_i,
    input  logic [num_channels_p-1:0]               v_i,
    input  logic [num_channels_p-1:0]               ready_yumi_i,
    input  logic [num_channels_p*data_width_p-1:0]  data_i,
    output logic [num_channels_p-1:0]               err_o,
    output logic [num_channels_p*3-1:0]             err_code_o,
    output logic [num_channels_p*count_width_p-1:0] txn_count_o,
    output logic [count_width_p-1:0]                max_stall_o,
    output logic                                    any_err_o
);

    logic [count_width_p-1:0] w_stall [num_channels_p];
    logic [count_width_p-1:0] w_max_now;
    logic [count_width_p-1:0] r_max_stall;

    for (genvar gi = 0; gi < num_channels_p; gi++) begin : g_ch
        bp_nonsynth_if_monitor_channel #(
            .data_width_p  (data_width_p),
            .timeout_p     (timeout_p),
            .yumi_mode_p   (yumi_mode_p),
            .count_width_p (count_width_p)
        ) u_ch (
            .i_clk        (clk_i),
            .i_rst        (reset_i),
            .i_clear      (clear_i),
            .i_v          (v_i[gi]),
            .i_ready_yumi (ready_yumi_i[gi]),
            .i_data       (data_i[gi*data_width_p +: data_width_p]),
            .o_err        (err_o[gi]),
            .o_err_code   (err_code_o[gi*3 +: 3]),
            .o_txn_count  (txn_count_o[gi*count_width_p +: count_width_p]),
            .o_stall_cnt  (w_stall[gi])
        );
    end

    // Worst stall seen so far, including any stall still in progress
    always_comb begin
        w_max_now = r_max_stall;
        for (int i = 0; i < num_channels_p; i++) begin
            if (w_stall[i] > w_max_now) begin
                w_max_now = w_stall[i];
            end
        end
    end

    // Remember completed stalls after their channel counter returns to zero
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_max_stall <= '0;
        end else if (clear_i) begin
            r_max_stall <= '0;
        end else begin
            r_max_stall <= w_max_now;
        end
    end

    assign max_stall_o = w_max_now;
    assign any_err_o   = |err_o;

endmodule : bp_nonsynth_if_monitor
`default_nettype wire

// File: tb/tb_bp_nonsynth_if_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_bp_nonsynth_if_monitor
// Description : Directed self-checking bench for bp_nonsynth_if_monitor.
//               dut_a: ready/valid, timeout 8. dut_b: valid/yumi, no timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bp_nonsynth_if_monitor;

    logic        clk;
    logic        rst;
    logic        clear;
    logic [3:0]  a_v, a_r, b_v, b_y;
    logic [63:0] a_data, b_data;
    logic [3:0]  a_err, b_err;
    logic [11:0] a_code, b_code;
    logic [31:0] a_cnt, b_cnt;
    logic [7:0]  a_max, b_max;
    logic        a_any, b_any;

    int n_cmp = 0;
    int n_bad = 0;

    bp_nonsynth_if_monitor #(
        .num_channels_p(4), .data_width_p(16), .timeout_p(8),
        .yumi_mode_p(0), .count_width_p(8)
    ) dut_a (
        .clk_i(clk), .reset_i(rst), .clear_i(clear),
        .v_i(a_v), .ready_yumi_i(a_r), .data_i(a_data),
        .err_o(a_err), .err_code_o(a_code), .txn_count_o(a_cnt),
        .max_stall_o(a_max), .any_err_o(a_any)
    );

    bp_nonsynth_if_monitor #(
        .num_channels_p(4), .data_width_p(16), .timeout_p(0),
        .yumi_mode_p(1), .count_width_p(8)
    ) dut_b (
        .clk_i(clk), .reset_i(rst), .clear_i(clear),
        .v_i(b_v), .ready_yumi_i(b_y), .data_i(b_data),
        .err_o(b_err), .err_code_o(b_code), .txn_count_o(b_cnt),
        .max_stall_o(b_max), .any_err_o(b_any)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        n_cmp++; if (a_err !== 4'h0 || a_any !== 1'b0) begin n_bad++; $display("FAIL reset_err_a: got %h/%b want 0/0", a_err, a_any); end
        n_cmp++; if (a_code !== 12'h0 || a_cnt !== 32'h0 || a_max !== 8'h0) begin n_bad++; $display("FAIL reset_regs_a: got code %h cnt %h max %h want 0", a_code, a_cnt, a_max); end
        n_cmp++; if (b_err !== 4'h0 || b_code !== 12'h0 || b_cnt !== 32'h0 || b_max !== 8'h0) begin n_bad++; $display("FAIL reset_b: got err %h code %h cnt %h max %h want 0", b_err, b_code, b_cnt, b_max); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_handshake();
        a_v[0] = 1'b1; a_r[0] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            a_data[15:0] = 16'(i + 1);
            tick();
        end
        a_v[0] = 1'b0; a_r[0] = 1'b0;
        n_cmp++; if (a_cnt[7:0] !== 8'd10) begin n_bad++; $display("FAIL hs_count: got %0d want 10", a_cnt[7:0]); end
        n_cmp++; if (a_err !== 4'h0 || a_max !== 8'd0) begin n_bad++; $display("FAIL hs_clean: got err %h max %0d want 0 0", a_err, a_max); end
        do_clear();
    endtask

    task automatic test_stall();
        a_v[1] = 1'b1; a_r[1] = 1'b0; a_data[31:16] = 16'hDEAD;
        tick(); tick(); tick();
        n_cmp++; if (a_max !== 8'd3 || a_cnt[15:8] !== 8'd0) begin n_bad++; $display("FAIL stall_mid: got max %0d cnt %0d want 3 0", a_max, a_cnt[15:8]); end
        a_r[1] = 1'b1;
        tick();
        a_v[1] = 1'b0; a_r[1] = 1'b0;
        tick();
        n_cmp++; if (a_cnt[15:8] !== 8'd1 || a_max !== 8'd3 || a_err !== 4'h0) begin n_bad++; $display("FAIL stall_done: got cnt %0d max %0d err %h want 1 3 0", a_cnt[15:8], a_max, a_err); end
        do_clear();
        n_cmp++; if (a_max !== 8'd0) begin n_bad++; $display("FAIL clear_max: got %0d want 0", a_max); end
    endtask

    task automatic test_unstable();
        a_v[2] = 1'b1; a_r[2] = 1'b0; a_data[47:32] = 16'h0005;
        tick();
        n_cmp++; if (a_err !== 4'h0) begin n_bad++; $display("FAIL unstable_pre: got err %h want 0", a_err); end
        a_data[47:32] = 16'h0006;
        tick();
        n_cmp++; if (a_err !== 4'b0100 || a_code[8:6] !== 3'd2 || a_any !== 1'b1) begin n_bad++; $display("FAIL unstable: got err %h code %0d any %b want 4 2 1", a_err, a_code[8:6], a_any); end
        n_cmp++; if (a_code[5:0] !== 6'd0 || a_code[11:9] !== 3'd0) begin n_bad++; $display("FAIL unstable_others: got codes %h want only ch2", a_code); end
        a_v[2] = 1'b0;
        do_clear();
    endtask

    task automatic test_drop();
        a_v[1] = 1'b1; a_r[1] = 1'b0; a_data[31:16] = 16'h1234;
        tick();
        a_v[1] = 1'b0;
        tick();
        n_cmp++; if (a_err !== 4'b0010 || a_code[5:3] !== 3'd1) begin n_bad++; $display("FAIL drop: got err %h code %0d want 2 1", a_err, a_code[5:3]); end
        do_clear();
    endtask

    task automatic test_timeout();
        a_v[3] = 1'b1; a_r[3] = 1'b0; a_data[63:48] = 16'h0077;
        for (int i = 0; i < 8; i++) tick();
        n_cmp++; if (a_err[3] !== 1'b0 || a_max !== 8'd8) begin n_bad++; $display("FAIL timeout_pre: got err %b max %0d want 0 8", a_err[3], a_max); end
        tick();
        n_cmp++; if (a_err[3] !== 1'b1 || a_code[11:9] !== 3'd3) begin n_bad++; $display("FAIL timeout: got err %b code %0d want 1 3", a_err[3], a_code[11:9]); end
        a_r[3] = 1'b1;
        tick();
        a_v[3] = 1'b0; a_r[3] = 1'b0;
        n_cmp++; if (a_cnt[31:24] !== 8'd1 || a_err[3] !== 1'b1 || a_code[11:9] !== 3'd3) begin n_bad++; $display("FAIL timeout_sticky: got cnt %0d err %b code %0d want 1 1 3", a_cnt[31:24], a_err[3], a_code[11:9]); end
        do_clear();
        n_cmp++; if (a_err !== 4'h0 || a_cnt[31:24] !== 8'd0 || a_any !== 1'b0) begin n_bad++; $display("FAIL timeout_clear: got err %h cnt %0d any %b want 0 0 0", a_err, a_cnt[31:24], a_any); end
    endtask

    task automatic test_saturation();
        a_v[0] = 1'b1; a_r[0] = 1'b1;
        for (int i = 0; i < 260; i++) tick();
        n_cmp++; if (a_cnt[7:0] !== 8'hFF) begin n_bad++; $display("FAIL sat_count: got %0d want 255", a_cnt[7:0]); end
        do_clear();
        n_cmp++; if (a_cnt[7:0] !== 8'd0) begin n_bad++; $display("FAIL clear_wins: got %0d want 0", a_cnt[7:0]); end
        tick();
        a_v[0] = 1'b0; a_r[0] = 1'b0;
        n_cmp++; if (a_cnt[7:0] !== 8'd1) begin n_bad++; $display("FAIL post_clear_count: got %0d want 1", a_cnt[7:0]); end
        do_clear();
    endtask

    task automatic test_yumi();
        b_v[1] = 1'b1; b_y[1] = 1'b0; b_data[31:16] = 16'h0005;
        b_v[2] = 1'b1; b_y[2] = 1'b0; b_data[47:32] = 16'h0009;
        tick();
        n_cmp++; if (b_err !== 4'h0 || b_max !== 8'd1) begin n_bad++; $display("FAIL yumi_pre: got err %h max %0d want 0 1", b_err, b_max); end
        b_v[0] = 1'b0; b_y[0] = 1'b1;
        b_data[31:16] = 16'h0006;
        b_v[2] = 1'b0; b_y[2] = 1'b1;
        tick();
        b_y = 4'h0; b_v = 4'h0;
        n_cmp++; if (b_err !== 4'b0111 || b_any !== 1'b1) begin n_bad++; $display("FAIL yumi_err: got err %h any %b want 7 1", b_err, b_any); end
        n_cmp++; if (b_code !== {3'd0, 3'd1, 3'd2, 3'd4}) begin n_bad++; $display("FAIL yumi_codes: got %h want %h", b_code, {3'd0, 3'd1, 3'd2, 3'd4}); end
        do_clear();
    endtask

    task automatic test_async_reset();
        a_v[1] = 1'b1; a_r[1] = 1'b0; a_data[31:16] = 16'hBEEF;
        a_v[2] = 1'b1; a_r[2] = 1'b1;
        tick(); tick();
        a_v[2] = 1'b0; a_r[2] = 1'b0;
        n_cmp++; if (a_max !== 8'd2 || a_cnt[23:16] !== 8'd2) begin n_bad++; $display("FAIL areset_pre: got max %0d cnt %0d want 2 2", a_max, a_cnt[23:16]); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (a_max !== 8'd0 || a_cnt !== 32'h0 || a_err !== 4'h0 || a_code !== 12'h0) begin n_bad++; $display("FAIL areset_async: got max %0d cnt %h err %h code %h want 0", a_max, a_cnt, a_err, a_code); end
        a_v[1] = 1'b0;
        #1 rst = 1'b0;
        tick();
        n_cmp++; if (a_err !== 4'h0 || a_max !== 8'd0) begin n_bad++; $display("FAIL areset_idle: got err %h max %0d want 0 0", a_err, a_max); end
        a_v[1] = 1'b1; a_r[1] = 1'b1; a_data[31:16] = 16'h0001;
        tick();
        a_v[1] = 1'b0; a_r[1] = 1'b0;
        tick();
        n_cmp++; if (a_cnt[15:8] !== 8'd1 || a_err !== 4'h0) begin n_bad++; $display("FAIL areset_resume: got cnt %0d err %h want 1 0", a_cnt[15:8], a_err); end
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0;
        a_v = '0; a_r = '0; a_data = '0;
        b_v = '0; b_y = '0; b_data = '0;
        test_reset();
        test_handshake();
        test_stall();
        test_unstable();
        test_drop();
        test_timeout();
        test_saturation();
        test_yumi();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, compared %0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

endmodule : tb_bp_nonsynth_if_monitor
`default_nettype wire
